// File: rtl/draw_map.sv
// Tile-map renderer: walks a COLS x ROWS cell map in row-major order and
// issues one 4x4 square request per drawn cell to a downstream square drawer.
module draw_map #(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [8:0] x_origin_i,
  input  logic [7:0] y_origin_i,
  input  logic [2:0] wall_colour_i,
  input  logic [2:0] floor_colour_i,
  input  logic       draw_floor_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] map_addr_o,
  input  logic       map_data_i,
  output logic       sq_start_o,
  input  logic       sq_done_i,
  output logic [8:0] sq_x_o,
  output logic [7:0] sq_y_o,
  output logic [2:0] sq_colour_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_SQ, NEXT, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0]    x_org_q, x_org_d;
  logic [7:0]    y_org_q, y_org_d;
  logic [2:0]    wall_q, wall_d;
  logic [2:0]    floor_q, floor_d;
  logic          dfl_q, dfl_d;
  logic [8:0]    sq_x_q, sq_x_d;
  logic [7:0]    sq_y_q, sq_y_d;
  logic [2:0]    sq_col_q, sq_col_d;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    x_org_d  = x_org_q;
    y_org_d  = y_org_q;
    wall_d   = wall_q;
    floor_d  = floor_q;
    dfl_d    = dfl_q;
    sq_x_d   = sq_x_q;
    sq_y_d   = sq_y_q;
    sq_col_d = sq_col_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          col_d   = '0;
          row_d   = '0;
          x_org_d = x_origin_i;
          y_org_d = y_origin_i;
          wall_d  = wall_colour_i;
          floor_d = floor_colour_i;
          dfl_d   = draw_floor_i;
        end
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        // Cell pitch is 4 pixels; sums wrap at the screen width/height.
        sq_x_d   = x_org_q + 9'({col_q, 2'b00});
        sq_y_d   = y_org_q + 8'({row_q, 2'b00});
        sq_col_d = map_data_i ? wall_q : floor_q;
        state_d  = (map_data_i || dfl_q) ? ISSUE : NEXT;
      end
      ISSUE: state_d = WAIT_SQ;
      WAIT_SQ: begin
        if (sq_done_i) state_d = NEXT;
      end
      NEXT: begin
        if (row_q == ROW_LAST && col_q == COL_LAST) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      x_org_q  <= '0;
      y_org_q  <= '0;
      wall_q   <= '0;
      floor_q  <= '0;
      dfl_q    <= 1'b0;
      sq_x_q   <= '0;
      sq_y_q   <= '0;
      sq_col_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_org_q  <= x_org_d;
      y_org_q  <= y_org_d;
      wall_q   <= wall_d;
      floor_q  <= floor_d;
      dfl_q    <= dfl_d;
      sq_x_q   <= sq_x_d;
      sq_y_q   <= sq_y_d;
      sq_col_q <= sq_col_d;
    end
  end

  // Counters only move in NEXT, so the address is stable through FETCH and WAIT_DATA.
  assign map_addr_o  = 8'(row_q) * 8'(COLS) + 8'(col_q);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign sq_start_o  = (state_q == ISSUE);
  assign sq_x_o      = sq_x_q;
  assign sq_y_o      = sq_y_q;
  assign sq_colour_o = sq_col_q;

endmodule

// File: doc/draw_map.md
DRAW_MAP -- requirements
Module: draw_map

Interface
REQ-001 Parameter COLS, default 16, meaning number of map columns; SHALL be a power of two ≤ 16.
REQ-002 Parameter ROWS, default 16, meaning number of map rows; SHALL be a power of two ≤ 16.
REQ-003 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin drawing the whole map; sampled only in IDLE.
REQ-006 x_origin  in  9  screen x of the map's top-left pixel; latched on accepted start.
REQ-007 y_origin  in  8  screen y of the map's top-left pixel; latched on accepted start.
REQ-008 wall_colour  in  3  and floor_colour  in  3  cell colours; latched on accepted start.
REQ-009 draw_floor  in  1  1 = draw floor cells, 0 = skip them; latched on accepted start.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the whole map is finished.
REQ-012 map_addr  out  8  cell address, row*COLS + col, zero-extended.
REQ-013 map_data  in  1  cell value, 1 = wall; valid exactly one cycle after map_addr is presented.
REQ-014 sq_start  out  1  one-cycle request to the downstream 4x4 square drawer.
REQ-015 sq_done  in  1  one-cycle completion pulse from the square drawer.
REQ-016 sq_x  out  9, sq_y  out  8, sq_colour  out  3  square top-left corner and colour; registered and held stable from sq_start until the next ISSUE.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_SQ, NEXT and DONE.
REQ-018 Transitions SHALL be:
- IDLE→FETCH on start; otherwise stay in IDLE.
- FETCH→WAIT_DATA.
- WAIT_DATA→ISSUE if map_data=1 or draw_floor=1; otherwise →NEXT.
- ISSUE→WAIT_SQ.
- WAIT_SQ→NEXT on sq_done; otherwise stay in WAIT_SQ.
- NEXT→DONE on the last cell; otherwise →FETCH.
- DONE→IDLE.
REQ-019 An accepted start SHALL clear the row and col counters to 0.
REQ-020 map_addr SHALL be driven from the counters in FETCH and held through WAIT_DATA.
REQ-021 In WAIT_DATA the block SHALL capture map_data and load the square registers:
- sq_x = x_origin + {col,2'b00}, truncated mod 512.
- sq_y = y_origin + {row,2'b00}, truncated mod 256.
- sq_colour = map_data ? wall_colour : floor_colour.
REQ-022 sq_start SHALL be high only in ISSUE, exactly one cycle per drawn cell.
REQ-023 sq_done SHALL be honoured only in WAIT_SQ; a pulse in any other state, including the ISSUE cycle, SHALL be ignored.
REQ-024 NEXT SHALL advance in row-major order: col increments, and col wraps from COLS-1 to 0 while row increments.
REQ-025 The last cell is row=ROWS-1, col=COLS-1; NEXT on that cell SHALL go to DONE and SHALL NOT wrap the counters.
REQ-026 done SHALL be high only in DONE, and busy SHALL fall in the same cycle that done falls.
REQ-027 start asserted while busy SHALL be ignored, and changes to the latched inputs while busy SHALL have no effect.
REQ-028 Per-cell latency SHALL be:
- 3 cycles for a skipped cell (FETCH, WAIT_DATA, NEXT).
- 4 + N cycles for a drawn cell, where N ≥ 1 is the number of cycles spent in WAIT_SQ.
REQ-029 The total time from the start cycle to done SHALL be 1 + Σ(per-cell latency) cycles, the final 1 being the DONE cycle.

Reset
REQ-030 On reset, from any state including mid-map, the block SHALL enter IDLE immediately without waiting for a clock edge.
REQ-031 On reset, the counters, all latched inputs, sq_x, sq_y, sq_colour and map_addr SHALL be 0, and sq_start, done and busy SHALL be 0.
REQ-032 After reset is released, the block SHALL require a new start before doing anything; an outstanding sq_done SHALL be ignored.

Verification
REQ-033 COLS=ROWS=2, origin (100,50), all-floor map, draw_floor=0, start -> no sq_start, done asserted in cycle 1+4*3=13, busy high in cycles 1..13.
REQ-034 COLS=ROWS=2, origin (0,0), map 1,0,0,1, draw_floor=1, wall 3'b100, floor 3'b001, sq_done 2 cycles after each sq_start -> four requests in order (0,0,4), (4,0,1), (0,4,1), (4,4,4).
REQ-035 Default 16x16, origin (500,250), cell (15,15) a wall -> sq_x=(500+60) mod 512=48, sq_y=(250+60) mod 256=54.
REQ-036 Drawer holds sq_done low for 20 cycles -> sq_start stays low and sq_x, sq_y, sq_colour stay unchanged throughout; a sq_done injected in the ISSUE cycle is ignored.
REQ-037 Reset asserted asynchronously while in WAIT_SQ -> busy, sq_start and done go to 0 at once; a second start pulse during the run, before the reset, is ignored.
REQ-038 After the REQ-037 reset is released, a new start -> the full map is redrawn from cell 0 with the newly latched origin.
